// File: rtl/keypad_emulator.sv
// Emulates a 4x4 hex keypad behind a row/column scanner: queued key codes are
// "pressed" for PRESS_CYCLES and released for GAP_CYCLES, pulling one row low.
module keypad_emulator #(
  parameter int PRESS_CYCLES = 1000,
  parameter int GAP_CYCLES   = 1000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [3:0]  keyCode,
  input  logic        keyValid,
  output logic        keyReady,
  input  logic [3:0]  col_n,
  output logic [3:0]  row_n,
  output logic        pressing,
  output logic        pressDone,
  output logic [15:0] pressCount
);

  localparam int MAX_CYCLES = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] PRESS_LOAD = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [15:0]      press_count, press_count_nxt;
  logic             pop, done;

  logic [3:0] fifo_mem [2];
  logic       wr_ptr, rd_ptr;
  logic [1:0] fifo_count;
  logic       push, fifo_empty;

  logic [3:0] active_key;
  logic [3:0] active_pos;
  logic [3:0] row_pull;

  // Returns {column, row} of a hex key on the physical keypad.
  function automatic logic [3:0] key_pos(input logic [3:0] key);
    case (key)
      4'h1: key_pos = {2'd0, 2'd0};
      4'h4: key_pos = {2'd0, 2'd1};
      4'h7: key_pos = {2'd0, 2'd2};
      4'hE: key_pos = {2'd0, 2'd3};
      4'h2: key_pos = {2'd1, 2'd0};
      4'h5: key_pos = {2'd1, 2'd1};
      4'h8: key_pos = {2'd1, 2'd2};
      4'h0: key_pos = {2'd1, 2'd3};
      4'h3: key_pos = {2'd2, 2'd0};
      4'h6: key_pos = {2'd2, 2'd1};
      4'h9: key_pos = {2'd2, 2'd2};
      4'hF: key_pos = {2'd2, 2'd3};
      4'hA: key_pos = {2'd3, 2'd0};
      4'hB: key_pos = {2'd3, 2'd1};
      4'hC: key_pos = {2'd3, 2'd2};
      default: key_pos = {2'd3, 2'd3};
    endcase
  endfunction

  assign fifo_empty = (fifo_count == 2'd0);
  assign keyReady   = (fifo_count != 2'd2);
  assign push       = keyValid & keyReady;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (push) fifo_mem[wr_ptr] <= keyCode;
    if (pop)  active_key <= fifo_mem[rd_ptr];
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      press_count <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      press_count <= press_count_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    pop             = 1'b0;
    done            = 1'b0;
    press_count_nxt = press_count;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          cnt_nxt   = PRESS_LOAD;
          state_nxt = PRESS;
        end
      end
      PRESS: begin
        if (cnt == '0) begin
          done            = 1'b1;
          cnt_nxt         = GAP_LOAD;
          press_count_nxt = press_count + 16'd1;
          state_nxt       = GAP;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      GAP: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - CNT_ONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pressing   = (state == PRESS);
  assign pressDone  = done & ~reset;
  assign pressCount = press_count;
  assign active_pos = key_pos(active_key);

  // Column c lives on col_n[3-c] and row r on row_n[3-r]; for 2-bit indices 3-x is ~x.
  always_comb begin
    row_pull = 4'b0000;
    if (state == PRESS && col_n[~active_pos[3:2]] == 1'b0)
      row_pull[~active_pos[1:0]] = 1'b1;
  end

  for (genvar i = 0; i < 4; i++) begin : g_row
    assign row_n[i] = row_pull[i] ? 1'b0 : 1'bz;
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Scoreboard bench for keypad_emulator: stimulus queues expected presses, a
// negedge monitor observes row responses and checks each completed press.
module tb_keypad_emulator;
  localparam int P = 4;
  localparam int G = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  keyCode;
  logic        keyValid;
  logic        keyReady;
  logic [3:0]  col_n;
  wire  [3:0]  row_n;
  logic        pressing;
  logic        pressDone;
  logic [15:0] pressCount;

  // Undriven rows read as 1, like the pull-ups on a real keypad.
  pullup pu0 (row_n[0]);
  pullup pu1 (row_n[1]);
  pullup pu2 (row_n[2]);
  pullup pu3 (row_n[3]);

  always #5 clk = ~clk;

  keypad_emulator #(.PRESS_CYCLES(P), .GAP_CYCLES(G)) dut (
    .CLOCK_50(clk), .reset(reset), .keyCode(keyCode), .keyValid(keyValid),
    .keyReady(keyReady), .col_n(col_n), .row_n(row_n), .pressing(pressing),
    .pressDone(pressDone), .pressCount(pressCount)
  );

  typedef struct {
    logic [3:0]  key;
    int          col;
    int          row;
    int          hits;
    int          sep;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad = 0;
  logic        scan = 1'b0;
  logic [15:0] model_cnt = 16'd0;

  // Hand-entered keypad table, indexed by key code.
  int tcol [16] = '{1, 0, 1, 2, 0, 1, 2, 0, 1, 2, 3, 3, 3, 3, 0, 2};
  int trow [16] = '{3, 0, 0, 0, 1, 1, 1, 2, 2, 2, 0, 1, 2, 3, 3, 3};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (scan) col_n = {col_n[0], col_n[3:1]};
  endtask

  task automatic push_key(input logic [3:0] k, input int c, input int r,
                          input int hits, input int sep, input bit track);
    int n;
    n = 0;
    keyCode  = k;
    keyValid = 1'b1;
    while (!keyReady && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) timeout("accept_wait");
    step();
    keyValid = 1'b0;
    if (track) begin
      model_cnt++;
      sbq.push_back('{k, c, r, hits, sep, model_cnt});
    end
  endtask

  task automatic wait_pressing();
    int n;
    n = 0;
    while (!pressing && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) timeout("wait_pressing");
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((sbq.size() != 0 || pressing) && n < 500) begin
      step();
      n++;
    end
    if (n >= 500) timeout("wait_done");
    repeat (G + 2) step();
  endtask

  // Monitor state
  bit          in_press = 0;
  bit          have_prev = 0;
  bit          chk_count = 0;
  bit          col_valid = 0;
  int          press_len = 0;
  int          hits = 0;
  int          obs_row = 0;
  int          obs_col = 0;
  int          idle_run = 0;
  int          sep_seen = 0;
  int          nlow = 0;
  int          ncol = 0;
  int          ridx = 0;
  int          cidx = 0;
  logic [15:0] pend_cnt = 16'd0;
  exp_t        e;

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      in_press  = 0;
      have_prev = 0;
      chk_count = 0;
      idle_run  = 0;
    end else if (reset === 1'b0) begin
      if (pressing) begin
        if (!in_press) begin
          in_press  = 1;
          press_len = 0;
          hits      = 0;
          col_valid = 0;
          obs_row   = -1;
          obs_col   = -1;
          sep_seen  = idle_run;
        end
        press_len++;
        if (row_n != 4'hF) begin
          hits++;
          nlow = 0;
          ncol = 0;
          for (int b = 0; b < 4; b++) begin
            if (!row_n[b]) begin nlow++; ridx = b; end
            if (!col_n[b]) begin ncol++; cidx = b; end
          end
          check("row_onehot", nlow, 1);
          obs_row = 3 - ridx;
          if (ncol == 1) begin
            obs_col   = 3 - cidx;
            col_valid = 1;
          end
        end
        if (pressDone) begin
          if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: pressCount %0h, none queued", pressCount);
          end else begin
            e = sbq.pop_front();
            check($sformatf("hits_k%h", e.key), hits, e.hits);
            check($sformatf("press_len_k%h", e.key), press_len, P);
            if (e.hits > 0) check($sformatf("row_k%h", e.key), obs_row, e.row);
            if (col_valid) check($sformatf("col_k%h", e.key), obs_col, e.col);
            if (e.sep != 0 && have_prev) check($sformatf("sep_k%h", e.key), sep_seen, e.sep);
            pend_cnt  = e.cnt;
            chk_count = 1;
          end
          in_press  = 0;
          have_prev = 1;
          idle_run  = 0;
        end
      end else begin
        check("row_idle", row_n, 4'hF);
        if (pressDone) begin
          total++;
          bad++;
          $display("FAIL done_outside_press: pressDone 1, want 0");
        end
        if (chk_count) begin
          check("press_count", pressCount, pend_cnt);
          chk_count = 0;
        end
        in_press = 0;
        idle_run++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    keyValid = 1'b0;
    keyCode  = 4'h0;
    col_n    = 4'b0000;
    repeat (3) step();
    check("rst_ready", keyReady, 1);
    check("rst_pressing", pressing, 0);
    check("rst_done", pressDone, 0);
    check("rst_count", pressCount, 0);
    check("rst_row", row_n, 4'hF);
    reset = 1'b0;
    step();

    // Key 5 with its column held selected: row 1 low for exactly P cycles.
    col_n = 4'b1011;
    push_key(4'h5, 1, 1, 4, 0, 1);
    check("k5_lat_row", row_n, 4'hF);
    check("k5_lat_pressing", pressing, 0);
    for (int i = 0; i < P; i++) begin
      step();
      check($sformatf("k5_row_%0d", i), row_n, 4'b1011);
      check($sformatf("k5_pressing_%0d", i), pressing, 1);
      check($sformatf("k5_done_%0d", i), pressDone, (i == P - 1));
    end
    step();
    check("k5_end_pressing", pressing, 0);
    check("k5_end_row", row_n, 4'hF);
    check("k5_count", pressCount, 1);
    wait_done();

    // Key A under a rotating scanner, then 1,2,3 queued while A is held.
    scan  = 1'b1;
    col_n = 4'b0111;
    push_key(4'hA, 3, 0, 1, 0, 1);
    wait_pressing();
    push_key(4'h1, 0, 0, 1, 4, 1);
    push_key(4'h2, 1, 0, 1, 4, 1);
    check("ready_full", keyReady, 0);
    push_key(4'h3, 2, 0, 1, 4, 1);
    wait_done();
    check("burst_count", pressCount, 5);

    // Reset on the second PRESS cycle of key E.
    scan  = 1'b0;
    col_n = 4'b0111;
    push_key(4'hE, 0, 3, 4, 0, 0);
    wait_pressing();
    check("kE_row", row_n, 4'b1110);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_cnt = 16'd0;
    check("mid_rst_row", row_n, 4'hF);
    check("mid_rst_pressing", pressing, 0);
    check("mid_rst_count", pressCount, 0);
    check("mid_rst_ready", keyReady, 1);
    repeat (P + G + 2) step();
    check("post_rst_count", pressCount, 0);

    // All columns selected at once still hits key 9's row.
    col_n = 4'b0000;
    push_key(4'h9, 2, 2, 4, 0, 1);
    wait_done();

    // Every key under scanner rotation.
    scan  = 1'b1;
    col_n = 4'b0111;
    for (int k = 0; k < 16; k++)
      push_key(k[3:0], tcol[k], trow[k], 1, (k == 0) ? 0 : 4, 1);
    wait_done();
    check("all_keys_count", pressCount, 17);

    // Wrap of the press counter.
    scan  = 1'b0;
    col_n = 4'b1011;
    @(negedge clk);
    force dut.press_count = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.press_count;
    check("forced_count", pressCount, 16'hFFFF);
    model_cnt = 16'hFFFF;
    push_key(4'h0, 1, 3, 4, 0, 1);
    wait_done();
    check("wrap_count", pressCount, 16'h0000);

    check("sb_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
